// File: rtl/fpu_pkg.sv
// fpu_pkg: operand class encoding, bias/emax derivation and canonical qNaN shared by FPU blocks
package fpu_pkg;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fcls_t;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic int emax(input int ew);
    return (1 << ew) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int ew, input int mw);
    return (64'(emax(ew)) << mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fmul_pipe_if.sv
// fmul_pipe_if: operand/result handshake bus; master drives in_valid/op1/op2/in_tag/out_ready, slave drives in_ready/out_valid/result/out_tag/ovf/unf/nv
interface fmul_pipe_if #(parameter int EXP_W = 8, parameter int MAN_W = 23, parameter int TAG_W = 4);
  localparam int W = EXP_W + MAN_W + 1;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic ovf;
  logic unf;
  logic nv;
  modport master (output in_valid, op1, op2, in_tag, out_ready, input in_ready, out_valid, result, out_tag, ovf, unf, nv);
  modport slave (input in_valid, op1, op2, in_tag, out_ready, output in_ready, out_valid, result, out_tag, ovf, unf, nv);
endinterface

// File: rtl/fmul_round.sv
// fmul_round: combinational round-to-nearest-even; i_man/i_guard/i_sticky/i_exp in, o_man/o_exp out (carry-out renormalises to 1.0, exp+1)
module fmul_round #(parameter int M = 24, parameter int EW = 10) (
  input  logic [M-1:0]         i_man,
  input  logic                 i_guard,
  input  logic                 i_sticky,
  input  logic signed [EW-1:0] i_exp,
  output logic [M-1:0]         o_man,
  output logic signed [EW-1:0] o_exp
);
  logic [M:0] w_sum;
  assign w_sum = {1'b0, i_man} + (M+1)'(i_guard & (i_sticky | i_man[0]));
  assign o_man = w_sum[M] ? {1'b1, {(M-1){1'b0}}} : w_sum[M-1:0];
  assign o_exp = i_exp + EW'(w_sum[M]);
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage IEEE-style multiplier with RNE, specials, flags, tag and valid/ready; ports clk, reset, bus (fmul_pipe_if.slave)
module fmul_pipe import fpu_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SPLIT = 11,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       reset,
  fmul_pipe_if.slave bus
);
  localparam int W = EXP_W + MAN_W + 1;
  localparam int M = MAN_W + 1;
  localparam int HW = M - SPLIT;
  localparam int P = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam int BIAS = bias(EXP_W);
  localparam logic signed [EW-1:0] EMAX_S = EW'(emax(EXP_W));
  localparam logic [63:0] QNAN64 = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN64[W-1:0];
  function automatic fcls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    return e == '0 ? CLS_ZERO : !(&e) ? CLS_NORM : f == '0 ? CLS_INF : CLS_NAN;
  endfunction
  logic w_adv;
  logic [M-1:0] w_ma, w_mb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic r1_v, r1_sgn;
  logic [2*HW-1:0] r1_hh;
  logic [M-1:0] r1_hl, r1_lh;
  logic [2*SPLIT-1:0] r1_ll;
  logic signed [EW-1:0] r1_exp;
  fcls_t r1_ca, r1_cb;
  logic [TAG_W-1:0] r1_tag;
  logic r2_v, r2_sgn;
  logic [P-1:0] r2_prod;
  logic signed [EW-1:0] r2_exp;
  fcls_t r2_ca, r2_cb;
  logic [TAG_W-1:0] r2_tag;
  logic r3_v, r3_ovf, r3_unf, r3_nv;
  logic [W-1:0] r3_res;
  logic [TAG_W-1:0] r3_tag;
  logic [P-1:0] w_norm;
  logic [M-1:0] w_man, w_rman;
  logic w_guard, w_sticky;
  logic signed [EW-1:0] w_exp_n, w_rexp;
  logic w_unused_hidden;
  logic [MAN_W-1:0] w_frac;
  logic w_nan, w_inf, w_zero, w_big, w_small;
  logic [W-1:0] w_res;
  assign w_adv = ~(r3_v & ~bus.out_ready);
  assign bus.in_ready = w_adv;
  assign w_ma = {1'b1, bus.op1[MAN_W-1:0]};
  assign w_mb = {1'b1, bus.op2[MAN_W-1:0]};
  assign w_ea = bus.op1[W-2:MAN_W];
  assign w_eb = bus.op2[W-2:MAN_W];
  // Normalise: a product in [1,2) has its leading one one place lower, so shift it up
  assign w_norm = r2_prod[P-1] ? r2_prod : r2_prod << 1;
  assign w_man = w_norm[P-1 -: M];
  assign w_guard = w_norm[P-1-M];
  assign w_sticky = |w_norm[P-2-M:0];
  assign w_exp_n = r2_exp + EW'(r2_prod[P-1]);
  fmul_round #(.M(M), .EW(EW)) u_round (
    .i_man(w_man), .i_guard(w_guard), .i_sticky(w_sticky), .i_exp(w_exp_n),
    .o_man(w_rman), .o_exp(w_rexp)
  );
  assign {w_unused_hidden, w_frac} = w_rman;
  assign w_nan = r2_ca == CLS_NAN || r2_cb == CLS_NAN || (r2_ca == CLS_INF && r2_cb == CLS_ZERO) || (r2_ca == CLS_ZERO && r2_cb == CLS_INF);
  assign w_inf = r2_ca == CLS_INF || r2_cb == CLS_INF;
  assign w_zero = r2_ca == CLS_ZERO || r2_cb == CLS_ZERO;
  assign w_big = w_rexp >= EMAX_S;
  assign w_small = w_rexp <= 0;
  always_comb begin
    w_res = w_nan ? QNAN :
            (w_inf || (!w_zero && w_big)) ? {r2_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
            (w_zero || w_small) ? {r2_sgn, {(W-1){1'b0}}} :
            {r2_sgn, w_rexp[EXP_W-1:0], w_frac};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
      r3_v <= 1'b0;
      r3_res <= '0;
      r3_tag <= '0;
      r3_ovf <= 1'b0;
      r3_unf <= 1'b0;
      r3_nv <= 1'b0;
    end else if (w_adv) begin
      r1_v <= bus.in_valid;
      r1_sgn <= bus.op1[W-1] ^ bus.op2[W-1];
      r1_hh <= (2*HW)'(w_ma[M-1:SPLIT]) * (2*HW)'(w_mb[M-1:SPLIT]);
      r1_hl <= M'(w_ma[M-1:SPLIT]) * M'(w_mb[SPLIT-1:0]);
      r1_lh <= M'(w_ma[SPLIT-1:0]) * M'(w_mb[M-1:SPLIT]);
      r1_ll <= (2*SPLIT)'(w_ma[SPLIT-1:0]) * (2*SPLIT)'(w_mb[SPLIT-1:0]);
      r1_exp <= EW'(w_ea) + EW'(w_eb) - EW'(BIAS);
      r1_ca <= classify(w_ea, bus.op1[MAN_W-1:0]);
      r1_cb <= classify(w_eb, bus.op2[MAN_W-1:0]);
      r1_tag <= bus.in_tag;
      r2_v <= r1_v;
      r2_sgn <= r1_sgn;
      r2_prod <= (P'(r1_hh) << (2*SPLIT)) + ((P'(r1_hl) + P'(r1_lh)) << SPLIT) + P'(r1_ll);
      r2_exp <= r1_exp;
      r2_ca <= r1_ca;
      r2_cb <= r1_cb;
      r2_tag <= r1_tag;
      r3_v <= r2_v;
      r3_res <= w_res;
      r3_tag <= r2_tag;
      r3_nv <= w_nan;
      r3_ovf <= !w_nan && !w_inf && !w_zero && w_big;
      r3_unf <= !w_nan && !w_inf && !w_zero && !w_big && w_small;
    end
  end
  assign bus.out_valid = r3_v;
  assign bus.result = r3_res;
  assign bus.out_tag = r3_tag;
  assign bus.ovf = r3_ovf;
  assign bus.unf = r3_unf;
  assign bus.nv = r3_nv;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed self-checking bench for fmul_pipe (latency, RNE, exceptions, specials, backpressure, reset flush)
module tb_fmul_pipe;
  logic clk;
  logic reset;
  int n_assert = 0;
  int n_fail = 0;
  fmul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();
  fmul_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag, input logic [31:0] er, input logic [2:0] ef);
    bus.in_valid = 1'b1;
    bus.op1 = a;
    bus.op2 = b;
    bus.in_tag = tag;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk({nm, "_early"}, 64'(bus.out_valid), 64'd0);
    tick();
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_result"}, 64'(bus.result), 64'(er));
    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({nm, "_flags"}, 64'({bus.ovf, bus.unf, bus.nv}), 64'(ef));
    tick();
  endtask
  initial begin
    int sent;
    int got;
    int seen;
    int bad;
    logic [35:0] held;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_flags", 64'({bus.ovf, bus.unf, bus.nv}), 64'd0);
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    run_vec("basic", 32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 3'b000);
    run_vec("rne_even", 32'h3F800800, 32'h3F800800, 4'd1, 32'h3F801000, 3'b000);
    run_vec("rne_odd", 32'h40400000, 32'h3F800001, 4'd2, 32'h40400002, 3'b000);
    run_vec("ovf", 32'h7F000000, 32'h7F000000, 4'd3, 32'h7F800000, 3'b100);
    run_vec("unf", 32'h00800000, 32'h00800000, 4'd4, 32'h00000000, 3'b010);
    run_vec("subn", 32'h80400000, 32'h3F800000, 4'd6, 32'h80000000, 3'b000);
    run_vec("inf_x_zero", 32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 3'b001);
    run_vec("neg_inf", 32'hFF800000, 32'h40000000, 4'd9, 32'hFF800000, 3'b000);
    run_vec("nan_in", 32'h7FC12345, 32'h3F800000, 4'd10, 32'h7FC00000, 3'b001);
    sent = 0;
    got = 0;
    seen = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus.in_valid = sent < 6;
      bus.op1 = 32'h40000000;
      bus.op2 = 32'h3F800000 + (32'(sent) << 20);
      bus.in_tag = 4'(8 + sent);
      if (bus.out_valid) seen++;
      bus.out_ready = seen > 5;
      #1;
      if (seen == 1) held = {bus.out_tag, bus.result};
      if (seen == 3) chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      if (seen == 5) chk("bp_hold", 64'({bus.out_tag, bus.result}), 64'(held));
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_result", 64'(bus.result), 64'(32'h40000000 + (32'(got) << 20)));
        chk("bp_tag", 64'(bus.out_tag), 64'(8 + got));
        got++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_got", 64'(got), 64'd6);
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_no_dup", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.op1 = 32'h40000000;
    bus.op2 = 32'h40000000;
    bus.in_tag = 4'd1;
    tick();
    bus.in_tag = 4'd2;
    tick();
    bus.in_tag = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    repeat (5) begin
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    chk("flush_no_valid", 64'(bad), 64'd0);
    run_vec("post_rst", 32'h40000000, 32'h40400000, 4'd12, 32'h40C00000, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
